// File: rtl/stack_alu_sequencer_pkg.sv
// rtl/stack_alu_sequencer_pkg.sv - command/state types and op decode for the stack ALU sequencer
package stack_alu_sequencer_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    CMD_PUSH = 2'b00,
    CMD_POP  = 2'b01,
    CMD_DUP  = 2'b10,
    CMD_OP   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_e;

  localparam logic [3:0] ALU_NOT = 4'b0111;
  localparam logic [3:0] ALU_NEG = 4'b1001;

  // Only NOT and NEG take a single operand; every other code, defined or not, pops two.
  function automatic logic is_unary(input logic [3:0] op);
    return (op == ALU_NOT) || (op == ALU_NEG);
  endfunction

endpackage

// File: rtl/stack_alu_sequencer_if.sv
// rtl/stack_alu_sequencer_if.sv - command handshake and ALU operand/result bus
interface stack_alu_sequencer_if;

  logic        CmdValid;
  logic        CmdReady;
  logic [1:0]  Cmd;
  logic [15:0] CmdData;
  logic [3:0]  CmdALUop;
  logic [15:0] AluA;
  logic [15:0] AluB;
  logic [3:0]  AluOp;
  logic [15:0] AluS;
  logic        AluIsZero;
  logic        AluOFL;

  modport master (
    output CmdValid, Cmd, CmdData, CmdALUop, AluS, AluIsZero, AluOFL,
    input  CmdReady, AluA, AluB, AluOp
  );

  modport slave (
    input  CmdValid, Cmd, CmdData, CmdALUop, AluS, AluIsZero, AluOFL,
    output CmdReady, AluA, AluB, AluOp
  );

endinterface

// File: rtl/stack_alu_sequencer_regfile.sv
// rtl/stack_alu_sequencer_regfile.sv - DEPTH x 16 operand stack storage
// Two combinational read ports (TOS, NOS), one synchronous write port, contents not reset.
module stack_alu_sequencer_regfile #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] tos_addr,
  input  logic [AW-1:0] nos_addr,
  output logic [15:0]   tos_data,
  output logic [15:0]   nos_data
);

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign tos_data = mem_q[tos_addr];
  assign nos_data = mem_q[nos_addr];

endmodule

// File: rtl/stack_alu_sequencer.sv
// rtl/stack_alu_sequencer.sv - operand stack front end sequencing PUSH/POP/DUP/OP into a 16-bit ALU
// Optional ALU_OFL_TRAP_EN: an overflowing OP is discarded and flagged as an error.
module stack_alu_sequencer
  import stack_alu_sequencer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   Reset,
  stack_alu_sequencer_if.slave   bus,
  output logic [15:0]            Tos,
  output logic [$clog2(DEPTH):0] Depth,
  output logic                   Empty,
  output logic                   Full,
  output logic                   ZeroFlag,
  output logic                   OflFlag,
  output logic                   Err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

  state_e      state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [15:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        res_z_q, res_z_d, res_ofl_q, res_ofl_d, pop2_q, pop2_d;
  logic        ready_q, ready_d, zero_q, zero_d, ofl_q, ofl_d, err_q, err_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata, tos_raw, nos_raw;
  logic          accept, empty, full, unary, wb_trap;
  logic [DW-1:0] op_pc, wb_pc;

  assign empty  = (depth_q == '0);
  assign full   = (depth_q == FULL_CNT);
  assign accept = bus.CmdValid & ready_q;
  assign unary  = is_unary(bus.CmdALUop);
  assign op_pc  = unary ? DW'(1) : DW'(2);
  assign wb_pc  = pop2_q ? DW'(2) : DW'(1);

`ifdef ALU_OFL_TRAP_EN
  assign wb_trap = res_ofl_q;
`else
  assign wb_trap = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    res_d     = res_q;
    res_z_d   = res_z_q;
    res_ofl_d = res_ofl_q;
    pop2_d    = pop2_q;
    zero_d    = zero_q;
    ofl_d     = ofl_q;
    err_d     = err_q;
    we        = 1'b0;
    waddr     = depth_q[AW-1:0];
    wdata     = bus.CmdData;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_e'(bus.Cmd))
            CMD_PUSH: begin
              if (full) err_d = 1'b1;
              else begin
                we      = 1'b1;
                depth_d = depth_q + DW'(1);
              end
            end
            CMD_POP: begin
              if (empty) err_d = 1'b1;
              else depth_d = depth_q - DW'(1);
            end
            CMD_DUP: begin
              if (empty || full) err_d = 1'b1;
              else begin
                we      = 1'b1;
                wdata   = tos_raw;
                depth_d = depth_q + DW'(1);
              end
            end
            default: begin
              // Operands are only copied out here; the stack itself is untouched until WB.
              if (depth_q < op_pc) err_d = 1'b1;
              else begin
                pop2_d   = ~unary;
                alu_a_d  = unary ? tos_raw : nos_raw;
                alu_b_d  = unary ? 16'h0 : tos_raw;
                alu_op_d = bus.CmdALUop;
                state_d  = ST_EXEC;
              end
            end
          endcase
        end
      end
      ST_EXEC: begin
        res_d     = bus.AluS;
        res_z_d   = bus.AluIsZero;
        res_ofl_d = bus.AluOFL;
        state_d   = ST_WB;
      end
      ST_WB: begin
        state_d = ST_IDLE;
        if (wb_trap) begin
          ofl_d = 1'b1;
          err_d = 1'b1;
        end else begin
          we      = 1'b1;
          waddr   = depth_q[AW-1:0] - wb_pc[AW-1:0];
          wdata   = res_q;
          depth_d = depth_q - wb_pc + DW'(1);
          zero_d  = res_z_q;
          ofl_d   = res_ofl_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      depth_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      res_q     <= '0;
      res_z_q   <= 1'b0;
      res_ofl_q <= 1'b0;
      pop2_q    <= 1'b0;
      ready_q   <= 1'b1;
      zero_q    <= 1'b0;
      ofl_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      res_q     <= res_d;
      res_z_q   <= res_z_d;
      res_ofl_q <= res_ofl_d;
      pop2_q    <= pop2_d;
      ready_q   <= ready_d;
      zero_q    <= zero_d;
      ofl_q     <= ofl_d;
      err_q     <= err_d;
    end
  end

  stack_alu_sequencer_regfile #(.DEPTH(DEPTH), .AW(AW)) u_regfile (
    .CLK      (CLK),
    .we       (we & ~Reset),
    .waddr    (waddr),
    .wdata    (wdata),
    .tos_addr (depth_q[AW-1:0] - AW'(1)),
    .nos_addr (depth_q[AW-1:0] - AW'(2)),
    .tos_data (tos_raw),
    .nos_data (nos_raw)
  );

  assign bus.CmdReady = ready_q;
  assign bus.AluA     = alu_a_q;
  assign bus.AluB     = alu_b_q;
  assign bus.AluOp    = alu_op_q;
  assign Tos          = empty ? 16'h0 : tos_raw;
  assign Depth        = depth_q;
  assign Empty        = empty;
  assign Full         = full;
  assign ZeroFlag     = zero_q;
  assign OflFlag      = ofl_q;
  assign Err          = err_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// tb/tb_stack_alu_sequencer.sv - bench pairing the sequencer with a behavioural ALU and a queue-based stack model
module tb_stack_alu_sequencer;

  localparam int DEPTH = 16;
  localparam int DW    = 5;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic [15:0]   Tos;
  logic [DW-1:0] Depth;
  logic          Empty, Full, ZeroFlag, OflFlag, Err;
  int            checks = 0;
  int            failures = 0;

  stack_alu_sequencer_if bus();

  stack_alu_sequencer #(.DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .bus      (bus.slave),
    .Tos      (Tos),
    .Depth    (Depth),
    .Empty    (Empty),
    .Full     (Full),
    .ZeroFlag (ZeroFlag),
    .OflFlag  (OflFlag),
    .Err      (Err)
  );

  always #5 CLK = ~CLK;

  // ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 XOR, 7 NOT, 8 ANDN, 9 NEG, others -1.
  function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    logic [15:0] s;
    logic        o;
    o = 1'b0;
    case (op)
      4'd0: begin s = a + b; o = (a[15] == b[15]) && (s[15] != a[15]); end
      4'd1: begin s = a - b; o = (a[15] != b[15]) && (s[15] != a[15]); end
      4'd2: s = a & b;
      4'd3: s = a | b;
      4'd4: s = a << 1;
      4'd5: s = a >> 1;
      4'd6: s = a ^ b;
      4'd7: s = ~a;
      4'd8: s = a & ~b;
      4'd9: begin s = -a; o = (a == 16'h8000); end
      default: s = 16'hFFFF;
    endcase
    return {o, s};
  endfunction

  assign {bus.AluOFL, bus.AluS} = alu_f(bus.AluA, bus.AluB, bus.AluOp);
  assign bus.AluIsZero = (bus.AluS == 16'h0);

  logic [15:0] m_stk[$];
  logic        m_zero, m_ofl, m_err, m_entered;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_tos();
    return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 16'h0;
  endfunction

  task automatic model_reset();
    m_stk.delete();
    m_zero = 1'b0; m_ofl = 1'b0; m_err = 1'b0;
    m_a = 16'h0; m_b = 16'h0; m_op = 4'h0;
  endtask

  task automatic model_cmd(input logic [1:0] c, input logic [15:0] d, input logic [3:0] op);
    int n;
    int pc;
    logic [16:0] r;
    n = m_stk.size();
    m_entered = 1'b0;
    case (c)
      2'd0: if (n == DEPTH) m_err = 1'b1; else m_stk.push_back(d);
      2'd1: if (n == 0) m_err = 1'b1; else void'(m_stk.pop_back());
      2'd2: if (n == 0 || n == DEPTH) m_err = 1'b1; else m_stk.push_back(m_stk[n-1]);
      default: begin
        pc = (op == 4'd7 || op == 4'd9) ? 1 : 2;
        if (n < pc) m_err = 1'b1;
        else begin
          m_entered = 1'b1;
          m_op = op;
          m_a  = (pc == 2) ? m_stk[n-2] : m_stk[n-1];
          m_b  = (pc == 2) ? m_stk[n-1] : 16'h0;
          r    = alu_f(m_a, m_b, op);
`ifdef ALU_OFL_TRAP_EN
          if (r[16]) begin
            m_ofl = 1'b1;
            m_err = 1'b1;
          end else begin
`else
          begin
`endif
            repeat (pc) void'(m_stk.pop_back());
            m_stk.push_back(r[15:0]);
            m_zero = (r[15:0] == 16'h0);
            m_ofl  = r[16];
          end
        end
      end
    endcase
  endtask

  task automatic check_state(input string t);
    chk({t, ":depth"}, 32'(Depth), 32'(m_stk.size()));
    chk({t, ":tos"},   32'(Tos), 32'(m_tos()));
    chk({t, ":empty"}, 32'(Empty), 32'(m_stk.size() == 0));
    chk({t, ":full"},  32'(Full), 32'(m_stk.size() == DEPTH));
    chk({t, ":zero"},  32'(ZeroFlag), 32'(m_zero));
    chk({t, ":ofl"},   32'(OflFlag), 32'(m_ofl));
    chk({t, ":err"},   32'(Err), 32'(m_err));
    chk({t, ":ready"}, 32'(bus.CmdReady), 32'(1));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.CmdValid = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic send(input string t, input logic [1:0] c, input logic [15:0] d, input logic [3:0] op);
    int n;
    int low;
    n = 0;
    low = 0;
    bus.CmdValid = 1'b1; bus.Cmd = c; bus.CmdData = d; bus.CmdALUop = op;
    while (bus.CmdReady !== 1'b1 && n < 20) begin @(posedge CLK); #1; n++; end
    chk({t, ":accept_timeout"}, 32'(n < 20), 32'(1));
    @(posedge CLK); #1;
    bus.CmdValid = 1'b0;
    bus.Cmd = 2'($urandom); bus.CmdData = 16'($urandom); bus.CmdALUop = 4'($urandom);
    model_cmd(c, d, op);
    while (bus.CmdReady !== 1'b1 && low < 20) begin low++; @(posedge CLK); #1; end
    chk({t, ":ready_low"}, 32'(low), m_entered ? 32'd2 : 32'd0);
    if (m_entered) begin
      chk({t, ":alu_a"},  32'(bus.AluA), 32'(m_a));
      chk({t, ":alu_b"},  32'(bus.AluB), 32'(m_b));
      chk({t, ":alu_op"}, 32'(bus.AluOp), 32'(m_op));
    end
    check_state(t);
  endtask

  initial begin
    logic [1:0]  c;
    logic [15:0] d;
    int          r;
    bus.CmdValid = 1'b0; bus.Cmd = 2'b00; bus.CmdData = 16'h0; bus.CmdALUop = 4'h0;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();
    check_state("reset");
    chk("reset:alu_a",  32'(bus.AluA), 32'(0));
    chk("reset:alu_b",  32'(bus.AluB), 32'(0));
    chk("reset:alu_op", 32'(bus.AluOp), 32'(0));

    // T1
    send("t1_push5", 2'd0, 16'd5, 4'h0);
    send("t1_push3", 2'd0, 16'd3, 4'h0);
    send("t1_sub",   2'd3, 16'h0, 4'b0001);
    chk("t1:tos",   32'(Tos), 32'(2));
    chk("t1:depth", 32'(Depth), 32'(1));
    chk("t1:zero",  32'(ZeroFlag), 32'(0));

    // T2
    do_reset();
    send("t2_push7a", 2'd0, 16'd7, 4'h0);
    send("t2_push7b", 2'd0, 16'd7, 4'h0);
    send("t2_xor",    2'd3, 16'h0, 4'b0110);
    chk("t2:tos",  32'(Tos), 32'(0));
    chk("t2:zero", 32'(ZeroFlag), 32'(1));
    send("t2_pop", 2'd1, 16'h0, 4'h0);
    chk("t2:empty", 32'(Empty), 32'(1));
    send("t2_pop_empty", 2'd1, 16'h0, 4'h0);
    chk("t2:err",   32'(Err), 32'(1));
    chk("t2:depth", 32'(Depth), 32'(0));

    // T3
    do_reset();
    send("t3_push1", 2'd0, 16'h0001, 4'h0);
    send("t3_neg",   2'd3, 16'h0, 4'b1001);
    chk("t3:tos_neg", 32'(Tos), 32'(16'hFFFF));
    chk("t3:depth1",  32'(Depth), 32'(1));
    send("t3_push2", 2'd0, 16'd2, 4'h0);
    send("t3_not",   2'd3, 16'h0, 4'b0111);
    chk("t3:tos_not", 32'(Tos), 32'(16'hFFFD));
    chk("t3:depth2",  32'(Depth), 32'(2));

    // T4
    do_reset();
    send("t4_push7fff", 2'd0, 16'h7FFF, 4'h0);
    send("t4_push1",    2'd0, 16'h0001, 4'h0);
    send("t4_add",      2'd3, 16'h0, 4'b0000);
`ifdef ALU_OFL_TRAP_EN
    chk("t4:depth", 32'(Depth), 32'(2));
    chk("t4:tos",   32'(Tos), 32'(1));
    chk("t4:err",   32'(Err), 32'(1));
`else
    chk("t4:depth", 32'(Depth), 32'(1));
    chk("t4:tos",   32'(Tos), 32'(16'h8000));
    chk("t4:err",   32'(Err), 32'(0));
`endif
    chk("t4:ofl", 32'(OflFlag), 32'(1));

    // T5
    do_reset();
    send("t5_push", 2'd0, 16'hA5C3, 4'h0);
    for (int i = 1; i < DEPTH; i++) send("t5_dup", 2'd2, 16'h0, 4'h0);
    chk("t5:full", 32'(Full), 32'(1));
    chk("t5:err_before", 32'(Err), 32'(0));
    send("t5_push_full", 2'd0, 16'h1234, 4'h0);
    chk("t5:err_full", 32'(Err), 32'(1));
    chk("t5:tos_kept", 32'(Tos), 32'(16'hA5C3));
    send("t5_dup_full", 2'd2, 16'h0, 4'h0);
    do_reset();
    send("t5_push_one", 2'd0, 16'h0042, 4'h0);
    send("t5_op_short", 2'd3, 16'h0, 4'b0000);
    chk("t5:err_short", 32'(Err), 32'(1));
    chk("t5:depth_short", 32'(Depth), 32'(1));

    // Idle cycles with junk on the command lines must hold everything.
    repeat (3) begin
      bus.Cmd = 2'($urandom); bus.CmdData = 16'($urandom); bus.CmdALUop = 4'($urandom);
      @(posedge CLK); #1;
    end
    check_state("idle_hold");

    // T6
    do_reset();
    send("t6_push4", 2'd0, 16'd4, 4'h0);
    send("t6_push6", 2'd0, 16'd6, 4'h0);
    bus.CmdValid = 1'b1; bus.Cmd = 2'd3; bus.CmdALUop = 4'b0000;
    @(posedge CLK); #1;
    bus.CmdValid = 1'b0;
    chk("t6:in_exec", 32'(bus.CmdReady), 32'(0));
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    model_reset();
    chk("t6:depth", 32'(Depth), 32'(0));
    chk("t6:ready", 32'(bus.CmdReady), 32'(1));
    chk("t6:alu_a", 32'(bus.AluA), 32'(0));
    repeat (2) @(posedge CLK);
    #1;
    check_state("t6_after");

    // Randomized command stream against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 79) do_reset();
      r = $urandom_range(0, 9);
      c = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      case ($urandom_range(0, 5))
        0: d = 16'h7FFF;
        1: d = 16'h8000;
        2: d = 16'h0000;
        default: d = 16'($urandom);
      endcase
      send("rand", c, d, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge CLK); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
